// File: rtl/regfile_rename_table.sv
// ============================================================================
// regfile_rename_table
//
// Architectural register file plus rename status table at the commit end of
// an 8-entry ROB. Dispatch renames rd to the allocated ROB tag. Commit writes
// the retired value and clears the mapping only if the mapping still points
// at the retiring tag. Flush drops every pending mapping but keeps rf.
//
// Source reads are combinational and resolve to one of:
//   x0                       -> data 0, not pending
//   busy, retiring this cycle -> commit_data (same-cycle forward)
//   busy                     -> pending, tag = producing ROB tag
//   not busy                 -> committed rf value
// Sources see the mapping as it was before this cycle's dispatch, so an
// instruction whose rs equals its own rd reads the previous producer.
//
// Optional feature (macro RF_CDB_FWD_EN): two result broadcast buses (add and
// mul). A busy source whose tag matches a valid broadcast takes the broadcast
// value. Priority is commit forward > add bus > mul bus. Broadcasts never
// change rf or busy state.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   disp_*                   dispatch: valid, rs1, rs2, rd, has_rd, ROB tag
//   src1_*, src2_*           operand data / pending flag / producer tag
//   commit_*                 in-order retirement: valid, tag, dest, data
//   flush                    ROB exception flush pulse
//   pending_count            number of busy (renamed) registers
//   cdb_add_*, cdb_mul_*     broadcast buses (only with RF_CDB_FWD_EN)
// ============================================================================
module regfile_rename_table #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int TAG_W    = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             disp_valid,
    input  logic [4:0]       disp_rs1,
    input  logic [4:0]       disp_rs2,
    input  logic [4:0]       disp_rd,
    input  logic             disp_has_rd,
    input  logic [TAG_W-1:0] disp_tag,

    output logic [XLEN-1:0]  src1_data,
    output logic             src1_is_tag,
    output logic [TAG_W-1:0] src1_tag,
    output logic [XLEN-1:0]  src2_data,
    output logic             src2_is_tag,
    output logic [TAG_W-1:0] src2_tag,

    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [4:0]       commit_dest_reg,
    input  logic [XLEN-1:0]  commit_data,

    input  logic             flush,
    output logic [5:0]       pending_count
`ifdef RF_CDB_FWD_EN
    ,
    input  logic             cdb_add_valid,
    input  logic [TAG_W-1:0] cdb_add_tag,
    input  logic [XLEN-1:0]  cdb_add_value,
    input  logic             cdb_mul_valid,
    input  logic [TAG_W-1:0] cdb_mul_tag,
    input  logic [XLEN-1:0]  cdb_mul_value
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]     rf_q   [NUM_REGS];
    logic [XLEN-1:0]     rf_d   [NUM_REGS];
    logic [TAG_W-1:0]    rtag_q [NUM_REGS];
    logic [TAG_W-1:0]    rtag_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [5:0]          pending_count_q;
    logic [5:0]          pending_count_d;

    logic commit_wr;
    logic disp_wr;

    assign commit_wr = commit_valid && (commit_dest_reg != 5'd0);
    assign disp_wr   = disp_valid && disp_has_rd && (disp_rd != 5'd0);

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        rf_d            = rf_q;
        rtag_d          = rtag_q;
        busy_d          = busy_q;
        pending_count_d = '0;

        // Retirement always writes rf; the mapping is released only when it
        // still names the retiring tag (a younger rename keeps it busy).
        if (commit_wr) begin
            rf_d[commit_dest_reg] = commit_data;
            if (rtag_q[commit_dest_reg] == commit_tag) begin
                busy_d[commit_dest_reg] = 1'b0;
            end
        end

        // Flush squashes the dispatching instruction too. Otherwise the new
        // rename is applied after the commit clear so it wins on the same rd.
        if (flush) begin
            busy_d = '0;
        end else if (disp_wr) begin
            busy_d[disp_rd] = 1'b1;
            rtag_d[disp_rd] = disp_tag;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            pending_count_d = pending_count_d + 6'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i]   <= '0;
                rtag_q[i] <= '0;
            end
            busy_q          <= '0;
            pending_count_q <= '0;
        end else begin
            rf_q            <= rf_d;
            rtag_q          <= rtag_d;
            busy_q          <= busy_d;
            pending_count_q <= pending_count_d;
        end
    end

    assign pending_count = pending_count_q;

    // ------------------------------------------------------------------
    // Operand reads (both sources share the same resolution logic)
    // ------------------------------------------------------------------
    logic [4:0]       src_idx    [2];
    logic [XLEN-1:0]  src_data   [2];
    logic             src_is_tag [2];
    logic [TAG_W-1:0] src_tag    [2];

    assign src_idx[0] = disp_rs1;
    assign src_idx[1] = disp_rs2;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_data[s]   = rf_q[src_idx[s]];
            src_is_tag[s] = 1'b0;
            src_tag[s]    = '0;
            if (src_idx[s] == 5'd0) begin
                src_data[s] = '0;
            end else if (busy_q[src_idx[s]]) begin
                if (commit_valid && (commit_tag == rtag_q[src_idx[s]]) &&
                    (commit_dest_reg == src_idx[s])) begin
                    src_data[s] = commit_data;
`ifdef RF_CDB_FWD_EN
                end else if (cdb_add_valid &&
                             (cdb_add_tag == rtag_q[src_idx[s]])) begin
                    src_data[s] = cdb_add_value;
                end else if (cdb_mul_valid &&
                             (cdb_mul_tag == rtag_q[src_idx[s]])) begin
                    src_data[s] = cdb_mul_value;
`endif
                end else begin
                    src_is_tag[s] = 1'b1;
                    src_tag[s]    = rtag_q[src_idx[s]];
                end
            end
        end
    end

    assign src1_data   = src_data[0];
    assign src1_is_tag = src_is_tag[0];
    assign src1_tag    = src_tag[0];
    assign src2_data   = src_data[1];
    assign src2_is_tag = src_is_tag[1];
    assign src2_tag    = src_tag[1];

endmodule

// File: doc/regfile_rename_table.md
Name: regfile_rename_table

Overview:
- Architectural register file plus rename status table; sits at the commit end of the ROB.
- Accepts one in-order commit per cycle: ROB tag, destination register and data. Writes the data and retires the rename mapping.
- Serves dispatch operand reads. Each source returns either a committed value or the ROB tag of its pending producer.
- On dispatch, records a new rename mapping for rd. On flush, drops all pending mappings.

Parameters:
NUM_REGS, 32, number of architectural registers (x0 hardwired to zero)
XLEN, 32, data width
TAG_W, 3, ROB tag width (8-entry ROB)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
disp_valid  input  1  dispatch of one instruction this cycle
disp_rs1  input  5  source 1 register index
disp_rs2  input  5  source 2 register index
disp_rd  input  5  destination register index
disp_has_rd  input  1  instruction writes rd (0 for branches)
disp_tag  input  TAG_W  ROB tag allocated to this instruction (ROB head pointer)
src1_data  output  XLEN  source 1 value, valid when src1_is_tag=0
src1_is_tag  output  1  source 1 pending; use src1_tag
src1_tag  output  TAG_W  ROB tag producing source 1
src2_data  output  XLEN  source 2 value
src2_is_tag  output  1  source 2 pending
src2_tag  output  TAG_W  ROB tag producing source 2
commit_valid  input  1  one-cycle commit strobe from ROB
commit_tag  input  TAG_W  ROB index being retired (tail pointer)
commit_dest_reg  input  5  architectural destination
commit_data  input  XLEN  value to write
flush  input  1  ROB exception flush, one-cycle pulse
pending_count  output  6  number of registers currently busy (renamed)

Behaviour:
- State:
  - rf[NUM_REGS] of XLEN bits.
  - busy[NUM_REGS] of 1 bit.
  - rtag[NUM_REGS] of TAG_W bits.
  - pending_count register.
- Reset (rst=1 at posedge): all rf=0, busy=0, rtag=0, pending_count=0. Outputs derived from this state therefore read data 0 with is_tag=0. Reset overrides commit, dispatch and flush in the same cycle.
- Source reads are combinational from current state plus commit bypass. For each source s:
  - If s==0: data=0, is_tag=0, tag=0.
  - Else if busy[s] and commit_valid and commit_tag==rtag[s] and commit_dest_reg==s: data=commit_data, is_tag=0 (same-cycle commit forward).
  - Else if busy[s]: is_tag=1, tag=rtag[s], data=rf[s] (don't-care).
  - Else: data=rf[s], is_tag=0, tag=0.
- Sources always see the mapping before this cycle's dispatch rename, so rs==rd of the same instruction reads the old producer.
- Commit (posedge, commit_valid=1, commit_dest_reg!=0):
  - rf[rd] <= commit_data unconditionally (in-order retirement).
  - busy[rd] cleared only if rtag[rd]==commit_tag and no same-cycle dispatch renames the same rd.
  - Commit to x0 is ignored entirely.
- Dispatch (posedge, disp_valid=1, disp_has_rd=1, disp_rd!=0): busy[rd]<=1, rtag[rd]<=disp_tag. This wins over a same-cycle commit clearing the same register.
- Dispatch with disp_has_rd=0 or rd=0 changes no state.
- pending_count: next value = number of set busy bits after the cycle's updates. Range 0..31; no wrap is possible.
- Flush (posedge, flush=1): all busy<=0 and pending_count<=0. rf is retained. A same-cycle commit still writes rf. A same-cycle dispatch is discarded, since its instruction is squashed.
- Latency: commit and dispatch become visible to reads on the cycle after the posedge. The commit value is also visible on the same cycle via the bypass.
- Dispatch while the ROB is full is the ROB's responsibility; this block performs no full check.

Optional Feature:
- Macro: RF_CDB_FWD_EN.
- When defined, adds these ports:
  - cdb_add_valid, cdb_add_tag[TAG_W], cdb_add_value[XLEN]
  - cdb_mul_valid, cdb_mul_tag[TAG_W], cdb_mul_value[XLEN]
- Read priority for a busy source whose tag matches a valid CDB tag: commit bypass > add bus > mul bus. The matching broadcast value is returned with is_tag=0.
- CDB broadcasts never modify rf or busy.
- When undefined: no CDB ports, and a busy source returns its tag.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> src1_data=0, src1_is_tag=0, src2_data=0, pending_count=0.
- Dispatch rd=5 tag=3; next cycle read rs1=5 -> src1_is_tag=1, src1_tag=3, pending_count=1.
- With r5 busy on tag 3, assert commit tag=3 rd=5 data=0x2A and read rs1=5 in the same cycle -> src1_data=0x2A, is_tag=0. Next cycle: busy clear, rf[5]=0x2A, pending_count=0.
- Dispatch rd=7 tag=1, then rd=7 tag=2, then commit tag=1 rd=7 data=9 -> rf[7]=9, r7 still busy with tag 2.
- Same-cycle commit tag=4 rd=6 and dispatch rd=6 tag=5 -> r6 busy, tag=5, rf[6]=commit value. Commit to rd=0 -> x0 still reads 0.
- Three registers busy, pulse flush -> all sources read rf values with is_tag=0, pending_count=0. Assert rst mid-sequence -> all state zero on the next cycle.
